clock_set_ctrl: RTL and testbench

Time-set controller for the hours/minutes clock. It sits between three raw push-buttons (mode, inc, dec) and the hour/minute counter datapath. It freezes the counters while the user edits hours and then minutes. On confirmation it issues a one-cycle load of the edited time. It also drives per-field blanking so the field being edited blinks on the four-digit seven-segment display.

---
 rtl/clock_set_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounced mode/inc/dec buttons drive an RUN/SET_HR/SET_MIN/COMMIT
// editor with idle abort and field blink. Define AUTO_REPEAT_EN to enable inc/dec auto-repeat.
module clock_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REPEAT_DLY   = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000,
    parameter int unsigned BLINK_HALF   = 25000000,
    parameter int unsigned IDLE_TIMEOUT = 1000000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] hr_in,
    input  logic [5:0] min_in,
    output logic       run_en,
    output logic       load,
    output logic [4:0] hr_out,
    output logic [5:0] min_out,
    output logic [1:0] set_mode,
    output logic       blank_hr,
    output logic       blank_min
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        COMMIT  = 2'b11
    } state_t;

    localparam logic [29:0] DB_LAST    = 30'(DEBOUNCE_CYC - 1);
    localparam logic [29:0] BLINK_LAST = 30'(BLINK_HALF - 1);
    localparam logic [29:0] IDLE_LAST  = 30'(IDLE_TIMEOUT - 1);

    // Bit 0 = mode, bit 1 = inc, bit 2 = dec.
    logic [2:0]  raw;
    logic [2:0]  sync1_q, sync2_q, db_q, db_prev_q, ev_q;
    logic [29:0] dbc_q [3];

    assign raw = {btn_dec, btn_inc, btn_mode};

    always_ff @(posedge clock) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            ev_q      <= '0;
            for (int unsigned i = 0; i < 3; i++) dbc_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            ev_q      <= db_q & ~db_prev_q;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DB_LAST) begin
                    db_q[i]  <= sync2_q[i];
                    dbc_q[i] <= '0;
                end else begin
                    dbc_q[i] <= dbc_q[i] + 30'd1;
                end
            end
        end
    end

    state_t      state_q, state_d;
    logic [4:0]  hr_q, hr_d;
    logic [5:0]  min_q, min_d;
    logic [29:0] idle_q, idle_d, blink_q, blink_d;
    logic        phase_q, phase_d;
    logic        run_en_q, load_q, blank_hr_q, blank_min_q;
    logic        mode_ev, inc_ev, dec_ev, step_ev, editing, changing;

    assign mode_ev = ev_q[0];

`ifdef AUTO_REPEAT_EN
    localparam logic [29:0] RPT_DLY  = 30'(REPEAT_DLY);
    localparam logic [29:0] RPT_RATE = 30'(REPEAT_RATE);

    // rcnt_q == 0 means disarmed; a press arms it at 1 so the first repeat lands REPEAT_DLY later.
    logic [29:0] rcnt_q [2];
    logic [1:0]  rfirst_q, rep;

    always_comb begin
        rep = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rep[i] = (rcnt_q[i] != '0) && db_q[i+1] &&
                     (rfirst_q[i] ? (rcnt_q[i] == RPT_DLY) : (rcnt_q[i] == RPT_RATE));
        end
    end

    assign inc_ev = ev_q[1] | rep[0];
    assign dec_ev = ev_q[2] | rep[1];

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (!rst || !editing || changing || !db_q[i+1]) begin
                rcnt_q[i]   <= '0;
                rfirst_q[i] <= 1'b1;
            end else if (ev_q[i+1] || rep[i]) begin
                rcnt_q[i]   <= 30'd1;
                rfirst_q[i] <= ev_q[i+1];
            end else if (rcnt_q[i] != '0) begin
                rcnt_q[i]   <= rcnt_q[i] + 30'd1;
            end
        end
    end
`else
    assign inc_ev = ev_q[1];
    assign dec_ev = ev_q[2];
`endif

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        step_ev = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mode_ev) begin
                    state_d = SET_HR;
                    hr_d    = hr_in;
                    min_d   = min_in;
                end
            end
            SET_HR, SET_MIN: begin
                if (mode_ev) begin
                    state_d = (state_q == SET_HR) ? SET_MIN : COMMIT;
                end else if (inc_ev != dec_ev) begin
                    step_ev = 1'b1;
                    if (state_q == SET_HR) begin
                        if (inc_ev) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        else        hr_d = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
                    end else begin
                        if (inc_ev) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        else        min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        editing  = (state_q == SET_HR) || (state_q == SET_MIN);
        changing = (state_d != state_q);
        idle_d   = (editing && !changing && !step_ev) ? idle_q + 30'd1 : '0;

        // Restart the blink on every edit so the changed digit shows at once.
        if (changing || step_ev) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + 30'd1;
            phase_d = phase_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q     <= RUN;
            hr_q        <= '0;
            min_q       <= '0;
            idle_q      <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            run_en_q    <= 1'b1;
            load_q      <= 1'b0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            run_en_q    <= (state_d == RUN);
            load_q      <= (state_d == COMMIT);
            blank_hr_q  <= (state_d == SET_HR) && phase_d;
            blank_min_q <= (state_d == SET_MIN) && phase_d;
        end
    end

    assign set_mode  = state_q;
    assign hr_out    = hr_q;
    assign min_out   = min_q;
    assign run_en    = run_en_q;
    assign load      = load_q;
    assign blank_hr  = blank_hr_q;
    assign blank_min = blank_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus a randomized
// button sequence checked against a field/state model of the time-set editor.
module tb_clock_set_ctrl;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [4:0] hr_in = '0;
    logic [5:0] min_in = '0;
    logic       run_en, load, blank_hr, blank_min;
    logic [4:0] hr_out;
    logic [5:0] min_out;
    logic [1:0] set_mode;
    logic [16:0] obs;

    int n_cmp = 0;
    int n_err = 0;
    int load_cnt = 0;

    clock_set_ctrl #(
        .DEBOUNCE_CYC(4),
        .REPEAT_DLY  (20),
        .REPEAT_RATE (5),
        .BLINK_HALF  (8),
        .IDLE_TIMEOUT(100)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .hr_in    (hr_in),
        .min_in   (min_in),
        .run_en   (run_en),
        .load     (load),
        .hr_out   (hr_out),
        .min_out  (min_out),
        .set_mode (set_mode),
        .blank_hr (blank_hr),
        .blank_min(blank_min)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (load === 1'b1) load_cnt++;

    assign obs = {set_mode, run_en, load, hr_out, min_out, blank_hr, blank_min};

    function automatic logic [16:0] pk(int s, bit r, bit l, int h, int m, bit bh, bit bm);
        return {2'(s), r, l, 5'(h), 6'(m), bh, bm};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Clean press: raw high 6 cycles, 16 cycles total; the FSM reacts 8 cycles after the rise.
    task automatic press(input bit m, input bit i, input bit d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        step(6);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        step(10);
    endtask

    task automatic test_reset;
        logic [16:0] e;
        rst = 1'b0;
        step(3);
        e = pk(0, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset: got %h want %h", obs, e); end
        rst = 1'b1;
        step(2);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset_release: got %h want %h", obs, e); end
    endtask

    task automatic test_mode_entry;
        logic [16:0] e;
        hr_in = 5'd13; min_in = 6'd45;
        btn_mode = 1'b1;
        step(7);
        e = pk(0, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL entry_early: got %h want %h", obs, e); end
        step(1);
        e = pk(1, 0, 0, 13, 45, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL entry_8cyc: got %h want %h", obs, e); end
        step(2);
        btn_mode = 1'b0;
        step(10);
    endtask

    task automatic test_debounce;
        btn_inc = 1'b1;
        step(3);
        btn_inc = 1'b0;
        step(12);
        n_cmp++;
        if ({set_mode, hr_out, min_out} !== {2'd1, 5'd13, 6'd45}) begin
            n_err++;
            $display("FAIL debounce_glitch: got mode %0d %0d:%0d want 1 13:45", set_mode, hr_out, min_out);
        end
    endtask

    task automatic test_full_sequence;
        logic [16:0] e;
        press(1, 0, 0);
        press(1, 0, 0);
        hr_in = 5'd10; min_in = 6'd0;
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        e = pk(2, 0, 0, 12, 59, 0, 1);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL seq_edit: got %h want %h", obs, e); end
        btn_mode = 1'b1;
        step(7);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL commit_pre: got %h want %h", obs, e); end
        step(1);
        e = pk(3, 0, 1, 12, 59, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL commit_load: got %h want %h", obs, e); end
        step(1);
        e = pk(0, 1, 0, 12, 59, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL commit_after: got %h want %h", obs, e); end
        btn_mode = 1'b0;
        step(10);
    endtask

    task automatic test_wrap;
        logic [16:0] e;
        int l0;
        hr_in = 5'd23; min_in = 6'd0;
        l0 = load_cnt;
        press(1, 0, 0);
        e = pk(1, 0, 0, 23, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_capture: got %h want %h", obs, e); end
        press(0, 1, 0);
        e = pk(1, 0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_hr_inc: got %h want %h", obs, e); end
        press(0, 0, 1);
        e = pk(1, 0, 0, 23, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_hr_dec: got %h want %h", obs, e); end
        press(0, 1, 1);
        n_cmp++;
        if ({set_mode, hr_out, min_out} !== {2'd1, 5'd23, 6'd0}) begin
            n_err++;
            $display("FAIL inc_dec_both: got mode %0d %0d:%0d want 1 23:0", set_mode, hr_out, min_out);
        end
        press(1, 0, 0);
        e = pk(2, 0, 0, 23, 0, 0, 1);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_to_min: got %h want %h", obs, e); end
        press(0, 0, 1);
        e = pk(2, 0, 0, 23, 59, 0, 1);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_min_dec: got %h want %h", obs, e); end
        press(1, 0, 0);
        e = pk(0, 1, 0, 23, 59, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_commit: got %h want %h", obs, e); end
        n_cmp++;
        if (load_cnt - l0 !== 1) begin n_err++; $display("FAIL wrap_load_count: got %0d want 1", load_cnt - l0); end
    endtask

    task automatic test_idle;
        logic [16:0] e;
        int l0;
        hr_in = 5'd7; min_in = 6'd30;
        press(1, 0, 0);
        l0 = load_cnt;
        btn_mode = 1'b1;
        step(6);
        btn_mode = 1'b0;
        step(2);
        for (int j = 0; j < 100; j++) begin
            e = pk(2, 0, 0, 7, 30, 0, bit'((j / 8) % 2));
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL idle_blink[%0d]: got %h want %h", j, obs, e); end
            step(1);
        end
        e = pk(0, 1, 0, 7, 30, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL idle_abort: got %h want %h", obs, e); end
        n_cmp++;
        if (load_cnt !== l0) begin n_err++; $display("FAIL idle_no_load: got %0d want %0d", load_cnt, l0); end
    endtask

    task automatic test_repeat;
        int exp_hr;
`ifdef AUTO_REPEAT_EN
        exp_hr = 10;
`else
        exp_hr = 6;
`endif
        hr_in = 5'd5; min_in = 6'd12;
        press(1, 0, 0);
        btn_inc = 1'b1;
        step(40);
        btn_inc = 1'b0;
        step(20);
        n_cmp++;
        if ({set_mode, hr_out, min_out} !== {2'd1, 5'(exp_hr), 6'd12}) begin
            n_err++;
            $display("FAIL repeat_hold: got mode %0d hr %0d min %0d want 1 %0d 12", set_mode, hr_out, min_out, exp_hr);
        end
    endtask

    task automatic test_reset_mid_hold;
        logic [16:0] e;
        e = pk(0, 1, 0, 0, 0, 0, 0);
        btn_inc = 1'b1;
        step(12);
        rst = 1'b0;
        step(1);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset_mid: got %h want %h", obs, e); end
        rst = 1'b1;
        step(20);
        btn_inc = 1'b0;
        step(10);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset_after_hold: got %h want %h", obs, e); end
    endtask

    task automatic test_random;
        int m_state, m_hr, m_min, m_loads, l0, op;
        logic [16:0] e;
        m_state = 0; m_hr = 0; m_min = 0; m_loads = 0;
        l0 = load_cnt;
        for (int k = 0; k < 40; k++) begin
            hr_in  = 5'($urandom_range(0, 23));
            min_in = 6'($urandom_range(0, 59));
            op = int'($urandom_range(0, 3));
            press(op == 0 || op == 3, op == 1 || op == 3, op == 2);
            if (op == 0 || op == 3) begin
                if (m_state == 0) begin
                    m_hr = int'(hr_in); m_min = int'(min_in); m_state = 1;
                end else if (m_state == 1) begin
                    m_state = 2;
                end else begin
                    m_state = 0; m_loads++;
                end
            end else if (m_state == 1) begin
                m_hr = (op == 1) ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
            end else if (m_state == 2) begin
                m_min = (op == 1) ? (m_min + 1) % 60 : (m_min + 59) % 60;
            end
            e = pk(m_state, m_state == 0, 0, m_hr, m_min, m_state == 1, m_state == 2);
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL rand[%0d] op %0d: got %h want %h", k, op, obs, e); end
            n_cmp++;
            if (load_cnt - l0 !== m_loads) begin
                n_err++;
                $display("FAIL rand_loads[%0d]: got %0d want %0d", k, load_cnt - l0, m_loads);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_entry();
        test_debounce();
        test_full_sequence();
        test_wrap();
        test_idle();
        test_repeat();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
